nco_bank_seq: RTL

//  Parametrised N-voice wavetable NCO bank. A single FSM time-multiplexes one step-size ROM

---
 rtl/nco_bank_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/nco_bank_seq.sv
// N-voice wavetable NCO bank: one FSM shares a step-size ROM port and a waveform ROM port
// across all voices, producing one velocity-scaled, mixed sample per prescaler tick.
module nco_bank_seq #(
  parameter int N_VOICES = 4,
  parameter int PW       = 16,
  parameter int WAW      = 7,
  parameter int SW       = 8,
  parameter int DIV      = 3125
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic [6:0]              program_id,
  input  logic [N_VOICES-1:0]     gate,
  input  logic [7*N_VOICES-1:0]   note_num,
  input  logic [7*N_VOICES-1:0]   note_vel,
  output logic                    step_re,
  output logic [6:0]              step_addr,
  input  logic [PW-1:0]           step_data,
  output logic                    wave_re,
  output logic [6+WAW:0]          wave_addr,
  input  logic [SW-1:0]           wave_data,
  output logic [SW-1:0]           sample_out,
  output logic                    sample_valid,
  output logic                    overrun
);

  localparam int VW = $clog2(N_VOICES);
  localparam int AW = SW + VW;
  localparam int CW = $clog2(DIV);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STEP  = 3'd1;
  localparam logic [2:0] S_PHASE = 3'd2;
  localparam logic [2:0] S_WAVE  = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]      state;
  logic [CW-1:0]   pre_cnt;
  logic            tick;
  logic [VW-1:0]   v;
  logic [AW-1:0]   acc;
  logic [PW-1:0]   phase [N_VOICES];
  logic [6:0]      step_addr_q;
  logic [6+WAW:0]  wave_addr_q;

  logic [6:0]      cur_note;
  logic [6:0]      cur_vel;
  logic            cur_gate;
  logic [PW-1:0]   cur_phase;
  logic [SW-1:0]   contrib;

  // Truncating velocity scale: full-scale velocity 127 maps to 127/128 of the sample.
  function automatic logic [SW-1:0] scale_vel(input logic [SW-1:0] s, input logic [6:0] vel);
    logic [SW+6:0] prod;
    prod = {7'b0, s} * {{SW{1'b0}}, vel};
    return prod[SW+6:7];
  endfunction

  assign tick      = ce && (pre_cnt == CW'(DIV - 1));
  assign cur_note  = note_num[7*v +: 7];
  assign cur_vel   = note_vel[7*v +: 7];
  assign cur_gate  = gate[v];
  assign cur_phase = phase[v];
  assign contrib   = cur_gate ? scale_vel(wave_data, cur_vel) : '0;

  // ROM addresses are live in their read state and hold the last issued value otherwise.
  assign step_re   = (state == S_STEP);
  assign wave_re   = (state == S_WAVE);
  assign step_addr = step_re ? cur_note : step_addr_q;
  assign wave_addr = wave_re ? {program_id, cur_phase[PW-1 -: WAW]} : wave_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (ce) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      v            <= '0;
      acc          <= '0;
      step_addr_q  <= '0;
      wave_addr_q  <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) phase[i] <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (tick && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_STEP;
            v     <= '0;
            acc   <= '0;
          end
        end
        // step-ROM read issued; data arrives for PHASE
        S_STEP: begin
          step_addr_q <= cur_note;
          state       <= S_PHASE;
        end
        // muted voices are parked at phase 0 so the next note-on starts cleanly
        S_PHASE: begin
          phase[v] <= cur_gate ? cur_phase + step_data : '0;
          state    <= S_WAVE;
        end
        // wave-ROM read issued with the freshly updated phase
        S_WAVE: begin
          wave_addr_q <= {program_id, cur_phase[PW-1 -: WAW]};
          state       <= S_ACC;
        end
        S_ACC: begin
          acc <= acc + AW'(contrib);
          if (v == VW'(N_VOICES - 1)) begin
            state <= S_OUT;
          end else begin
            v     <= v + 1'b1;
            state <= S_STEP;
          end
        end
        // divide by voice count; headroom in acc makes saturation unnecessary
        S_OUT: begin
          sample_out   <= acc[AW-1:VW];
          sample_valid <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
